ads_penirq_conditioner: RTL and testbench

Conditions the raw active-low PENIRQ pin of the ADS7843 touch controller before it reaches the touch-IRQ PIO input port. Provides a two-flop synchroniser, a symmetric debounce state machine, sticky press/release event flags with a level interrupt, and an 8-bit press counter. The clean level output `pen_down_n` drives the PIO `in_port` directly. The event and IRQ outputs feed the touch driver's interrupt path.

---
 rtl/ads_penirq_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_ads_penirq_conditioner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads_penirq_conditioner.sv
// ads_penirq_conditioner
//
// Cleans up the raw active-low PENIRQ pin of the ADS7843 touch controller
// before it reaches the touch-IRQ PIO input port and the driver's interrupt
// path. The signal path is:
//   - a two-flop synchroniser
//   - a symmetric debounce FSM (UP / DEB_DOWN / DOWN / DEB_UP)
//   - sticky press/release flags with a registered level interrupt
//   - an 8-bit wrapping press counter
//
// Optional feature (compile-time macro ADS_PENIRQ_RELEASE_IRQ_EN):
//   defined     : irq = press_flag | release_flag
//   not defined : irq = press_flag only. release_flag still sets and clears,
//                 but it never raises irq.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous, active-low reset
//   penirq_pin_n  in   raw pin, asynchronous, low = pen touching
//   ev_clr        in   one-cycle pulse, clears press/release flags
//   pen_down_n    out  debounced level, low = pen down (PIO in_port)
//   press_flag    out  sticky, a debounced press occurred
//   release_flag  out  sticky, a debounced release occurred
//   irq           out  registered level interrupt request
//   press_cnt     out  count of debounced presses, wraps at 256
//   dbg_state     out  current FSM state (UP=0, DEB_DOWN=1, DOWN=2, DEB_UP=3)
//
// Handshake: there is no valid/ready traffic here. ev_clr is a plain
// one-cycle strobe. If a flag is set on the same edge that ev_clr is
// sampled, the set wins.

module ads_penirq_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       penirq_pin_n,
    input  logic       ev_clr,
    output logic       pen_down_n,
    output logic       press_flag,
    output logic       release_flag,
    output logic       irq,
    output logic [7:0] press_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_UP       = 2'd0,
        ST_DEB_DOWN = 2'd1,
        ST_DOWN     = 2'd2,
        ST_DEB_UP   = 2'd3
    } state_t;

    // Terminal count: this is the last counting edge, on which the new level
    // is accepted.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pen_down_n;
    logic             r_press_flag;
    logic             r_release_flag;
    logic             r_irq;
    logic [7:0]       r_press_cnt;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_pen_next;
    logic             w_press_set;
    logic             w_release_set;
    logic             w_press_next;
    logic             w_release_next;
    logic             w_irq_next;
    logic [7:0]       w_press_cnt_next;

    // Two-flop synchroniser. Both flops reset to the released level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= penirq_pin_n;
            r_s2 <= r_s1;
        end
    end

    // Next-state logic for the FSM, the counter and the events.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_pen_next    = r_pen_down_n;
        w_press_set   = 1'b0;
        w_release_set = 1'b0;

        case (r_state)
            ST_UP: begin
                if (!r_s2) begin
                    w_state_next = ST_DEB_DOWN;
                    w_cnt_next   = '0;
                end
            end
            ST_DEB_DOWN: begin
                if (r_s2) begin
                    // Bounce: go back with no side effects.
                    w_state_next = ST_UP;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_next = ST_DOWN;
                    w_pen_next   = 1'b0;
                    w_press_set  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_DOWN: begin
                if (r_s2) begin
                    w_state_next = ST_DEB_UP;
                    w_cnt_next   = '0;
                end
            end
            ST_DEB_UP: begin
                if (!r_s2) begin
                    w_state_next = ST_DOWN;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_next  = ST_UP;
                    w_pen_next    = 1'b1;
                    w_release_set = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_UP;
            end
        endcase

        // A set overrides a clear issued on the same edge.
        w_press_next     = w_press_set   | (r_press_flag   & ~ev_clr);
        w_release_next   = w_release_set | (r_release_flag & ~ev_clr);
        w_press_cnt_next = r_press_cnt + {7'd0, w_press_set};

        // irq is built from the next-state flags, so it rises on the same
        // edge as the flag.
`ifdef ADS_PENIRQ_RELEASE_IRQ_EN
        w_irq_next = w_press_next | w_release_next;
`else
        w_irq_next = w_press_next;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_UP;
            r_cnt          <= '0;
            r_pen_down_n   <= 1'b1;
            r_press_flag   <= 1'b0;
            r_release_flag <= 1'b0;
            r_irq          <= 1'b0;
            r_press_cnt    <= 8'd0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_pen_down_n   <= w_pen_next;
            r_press_flag   <= w_press_next;
            r_release_flag <= w_release_next;
            r_irq          <= w_irq_next;
            r_press_cnt    <= w_press_cnt_next;
        end
    end

    assign pen_down_n   = r_pen_down_n;
    assign press_flag   = r_press_flag;
    assign release_flag = r_release_flag;
    assign irq          = r_irq;
    assign press_cnt    = r_press_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_ads_penirq_conditioner.sv
// tb_ads_penirq_conditioner
//
// Bench for ads_penirq_conditioner with DEBOUNCE_CYCLES = 4.
//
// The reference model does not copy the RTL state machine. Instead it keeps
// a pin-sample queue of depth two, which stands in for the synchroniser
// delay, and a run length of consecutive edges on which the synchronised
// level differs from the accepted level. When that run reaches
// DEBOUNCE_CYCLES+1, the accepted level flips and an event is raised.
//
// Build with +define+ADS_PENIRQ_RELEASE_IRQ_EN to check the release-irq
// variant.

module tb_ads_penirq_conditioner;

    localparam int D = 4;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       penirq_pin_n = 1'b0;
    logic       ev_clr       = 1'b0;
    logic       pen_down_n;
    logic       press_flag;
    logic       release_flag;
    logic       irq;
    logic [7:0] press_cnt;
    logic [1:0] dbg_state;

    ads_penirq_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .penirq_pin_n(penirq_pin_n),
        .ev_clr      (ev_clr),
        .pen_down_n  (pen_down_n),
        .press_flag  (press_flag),
        .release_flag(release_flag),
        .irq         (irq),
        .press_cnt   (press_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / check ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_level;      // accepted level, 1 = up
    int m_run;        // consecutive edges with synced level != accepted level
    bit m_press;
    bit m_rel;
    bit m_irq;
    int m_cnt;
    bit m_q[$];       // pin samples still travelling through the synchroniser

    task automatic model_reset();
        m_level = 1'b1;
        m_run   = 0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_irq   = 1'b0;
        m_cnt   = 0;
        m_q     = '{1'b1, 1'b1};
    endtask

    task automatic model_edge(input bit pin, input bit clr);
        bit seen;
        bit p_set;
        bit r_set;
        seen  = m_q.pop_front();
        m_q.push_back(pin);
        p_set = 1'b0;
        r_set = 1'b0;
        if (seen != m_level) m_run++;
        else                 m_run = 0;
        if (m_run == D + 1) begin
            m_level = seen;
            m_run   = 0;
            if (seen == 1'b0) begin
                p_set = 1'b1;
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                r_set = 1'b1;
            end
        end
        m_press = p_set ? 1'b1 : (clr ? 1'b0 : m_press);
        m_rel   = r_set ? 1'b1 : (clr ? 1'b0 : m_rel);
`ifdef ADS_PENIRQ_RELEASE_IRQ_EN
        m_irq = m_press | m_rel;
`else
        m_irq = m_press;
`endif
    endtask

    task automatic check_model();
        check_eq("pen_down_n", 32'(pen_down_n), 32'(m_level));
        check_eq("press_flag", 32'(press_flag), 32'(m_press));
        check_eq("release_flag", 32'(release_flag), 32'(m_rel));
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("press_cnt", 32'(press_cnt), 32'(m_cnt));
    endtask

    // ---------------- driver ----------------
    // Drive inputs away from the edge, clock once, update the model, then
    // sample the outputs 1 ns after the edge.
    task automatic step(input bit pin, input bit clr);
        penirq_pin_n = pin;
        ev_clr       = clr;
        @(posedge clk);
        if (reset_n) model_edge(pin, clr);
        #1;
        check_model();
    endtask

    // Hold the pin at a level and report the first edge on which pen_down_n
    // reaches want_pen, together with the flag and irq values on that edge.
    task automatic count_edges(input bit pin, input bit want_pen, input int max_edges,
                               output int edge_no, output bit flag_at, output bit irq_at);
        edge_no = 0;
        flag_at = 1'b0;
        irq_at  = 1'b0;
        for (int i = 1; i <= max_edges; i++) begin
            step(pin, 1'b0);
            if (edge_no == 0 && pen_down_n == want_pen) begin
                edge_no = i;
                flag_at = want_pen ? release_flag : press_flag;
                irq_at  = irq;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        bit f;
        bit q;
        bit pin;
        int run;
        bit exp_rel_irq;

`ifdef ADS_PENIRQ_RELEASE_IRQ_EN
        exp_rel_irq = 1'b1;
`else
        exp_rel_irq = 1'b0;
`endif
        model_reset();

        // Reset is held with the pin low.
        reset_n      = 1'b0;
        penirq_pin_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pen_down_n", 32'(pen_down_n), 32'd1);
        check_eq("rst_press_flag", 32'(press_flag), 32'd0);
        check_eq("rst_release_flag", 32'(release_flag), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_press_cnt", 32'(press_cnt), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);

        // Release reset with the pin still low. The press is accepted on edge 7.
        reset_n = 1'b1;
        count_edges(1'b0, 1'b0, 12, e, f, q);
        check_eq("press_edge", 32'(e), 32'd7);
        check_eq("press_flag_at_edge", 32'(f), 32'd1);
        check_eq("press_irq_at_edge", 32'(q), 32'd1);
        check_eq("press_cnt_1", 32'(press_cnt), 32'd1);

        // A lone clear drops the flag and irq.
        step(1'b0, 1'b1);
        check_eq("clr_press_flag", 32'(press_flag), 32'd0);
        check_eq("clr_irq", 32'(irq), 32'd0);

        // Release is accepted on edge 7; irq depends on the build.
        count_edges(1'b1, 1'b1, 12, e, f, q);
        check_eq("release_edge", 32'(e), 32'd7);
        check_eq("release_flag_at_edge", 32'(f), 32'd1);
        check_eq("release_irq_at_edge", 32'(q), 32'(exp_rel_irq));
        step(1'b1, 1'b1);

        // 3-cycle low bounce while up must be rejected.
        repeat (3) step(1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0);
        check_eq("bounce_pen_up", 32'(pen_down_n), 32'd1);
        check_eq("bounce_no_flag", 32'(press_flag), 32'd0);
        check_eq("bounce_cnt", 32'(press_cnt), 32'd1);

        // Clean press from up, then a 3-cycle high glitch while down.
        count_edges(1'b0, 1'b0, 12, e, f, q);
        check_eq("press2_edge", 32'(e), 32'd7);
        check_eq("press_cnt_2", 32'(press_cnt), 32'd2);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0);
        check_eq("glitch_pen_down", 32'(pen_down_n), 32'd0);
        check_eq("glitch_no_release", 32'(release_flag), 32'd0);

        // Clear collision: ev_clr lands on the same edge that the press sets.
        repeat (12) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) step(1'b0, (i == 7));
        check_eq("collide_press_flag", 32'(press_flag), 32'd1);
        check_eq("collide_irq", 32'(irq), 32'd1);
        step(1'b0, 1'b1);
        check_eq("after_clr_press_flag", 32'(press_flag), 32'd0);
        check_eq("after_clr_irq", 32'(irq), 32'd0);

        // Randomised pin runs and clears, checked against the model.
        pin = 1'b0;
        run = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run == 0) begin
                pin = ~pin;
                run = $urandom_range(1, 8);
            end
            run--;
            step(pin, ($urandom_range(0, 9) == 0));
        end

        // Reset in the middle of DEB_DOWN.
        repeat (12) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        check_eq("pre_rst_state", 32'(dbg_state), 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_state", 32'(dbg_state), 32'd0);
        check_eq("midrst_pen_down_n", 32'(pen_down_n), 32'd1);
        check_eq("midrst_press_flag", 32'(press_flag), 32'd0);
        check_eq("midrst_release_flag", 32'(release_flag), 32'd0);
        check_eq("midrst_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        penirq_pin_n = 1'b1;
        reset_n      = 1'b1;

        // 256 clean presses wrap press_cnt back to 0.
        for (int p = 0; p < 256; p++) begin
            repeat (6) step(1'b0, 1'b0);
            repeat (6) step(1'b1, 1'b1);
            if (p == 254) check_eq("cnt_255", 32'(press_cnt), 32'd255);
        end
        check_eq("cnt_wrap", 32'(press_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety bound so the run always ends by itself.
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL timeout: got=running expected=finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
